rec_ctrl: RTL and testbench
===========================

# rec_ctrl

Transport controller for the audio recorder. It sits between the debounced play/record buttons and the adc, dac and sram stages. It converts button presses into record/play/pause modes, generates the sram sample address, and issues one-cycle `write`/`read` strobes per audio frame. It also remembers how many samples were recorded, so playback stops at the end of the take.

## Interface
- `ADDR_W`, 18: sram word address width.
- `clk` in 1: system clock (12 MHz from pll); all logic on rising edge.
- `reset` in 1: synchronous, active-high; one cycle is sufficient.
- `play` in 1: debounced play button level; acted on at rising edge only.
- `record` in 1: debounced record button level; acted on at rising edge only.
- `sample_tick` in 1: one-cycle pulse per audio frame (adclrc/daclrc edge already synchronised to `clk`).
- `addr` out ADDR_W: sram word address for the current access.
- `write` out 1: one-cycle strobe; sram stores adc sample at `addr`.
- `read` out 1: one-cycle strobe; sram fetches sample at `addr` for dac.
- `rec_en` out 1: high while in RECORD; gates adc stage.
- `play_en` out 1: high while in PLAY; gates dac (dac outputs silence when low).
- `sample_count` out ADDR_W+1: number of samples in the stored take, 0..2^ADDR_W.
- `full` out 1: set when the last recording filled memory.
- `state` out 2: IDLE=0, RECORD=1, PLAY=2, PAUSE=3 (LED display).

## Operation
- Edge detect:
  - `play_q`/`record_q` register the inputs.
  - rise = in & ~q.
  - During reset the q registers load the current input, so a button held through reset produces no edge.
- Priority:
  - A record rise beats a play rise in the same cycle.
  - Any button rise beats `sample_tick` in the same cycle; that tick is dropped (no strobe).
- Internal pointer `ptr` (ADDR_W bits).
- IDLE:
  - record rise -> RECORD; ptr<=0, sample_count<=0, full<=0.
  - play rise with sample_count!=0 -> PLAY; ptr<=0.
  - play rise with sample_count==0 is ignored.
  - Ticks are ignored.
- RECORD:
  - tick -> write<=1, addr<=ptr, ptr<=ptr+1, sample_count<=ptr+1.
  - If ptr==2^ADDR_W-1 at that tick: full<=1, state->IDLE; ptr wraps to 0 and is unused.
  - record rise -> IDLE; the take ends with the current sample_count.
  - play rise is ignored.
- PLAY:
  - tick -> read<=1, addr<=ptr, ptr<=ptr+1.
  - If ptr+1==sample_count: state->IDLE after issuing that read.
  - play rise -> PAUSE; ptr is held.
  - record rise -> IDLE (stop, no recording started).
- PAUSE:
  - play rise -> PLAY, resuming at ptr.
  - record rise -> IDLE.
  - Ticks are ignored.
- `rec_en`=(state==RECORD) and `play_en`=(state==PLAY); both are registered with the state.
- `addr` holds its last value between strobes.
- `sample_count` persists across PLAY/PAUSE/IDLE until the next record start.

## Timing
- Reset values:
  - state=IDLE.
  - addr=0, ptr=0, sample_count=0.
  - write=0, read=0, full=0.
  - rec_en=0, play_en=0.
- Button: rise seen in cycle n -> state, rec_en, play_en updated at cycle n+1.
- Tick in cycle n -> strobe high in cycle n+1 only, with `addr` valid in the same cycle n+1.
  - Consecutive-cycle ticks each produce a strobe (back-to-back strobes are legal).
- Final access: the last write (full) or last read (end of take) strobes in cycle n+1, with state already IDLE and rec_en/play_en low in that same cycle.
- Reset mid-operation: next cycle all outputs are at reset values; the recorded take is lost (sample_count=0).

## Test plan
- Reset, then a record pulse, then 5 ticks, then a record pulse -> write strobes at addr 0..4, sample_count=5, state IDLE, full=0.
- After the take above: play pulse, then 7 ticks -> reads at addr 0..4 only; the 5th read coincides with state=IDLE; ticks 6 and 7 produce no strobe.
- Play at idle with sample_count=0 -> state stays IDLE, no strobes. Play and record rising in the same cycle -> RECORD.
- During PLAY at ptr=2: play pulse -> PAUSE, 3 ticks give no reads. Play pulse -> resume, next read at addr 2.
- ADDR_W=4, record with 16 ticks -> writes at 0..15, full=1, sample_count=16, state IDLE after the 16th write. The 17th tick is ignored.
- Record button held high through reset, then released and pressed -> no transition at reset exit; RECORD only on the new press. Reset asserted mid-RECORD -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/rec_ctrl.sv
// Transport controller for the audio recorder: turns play/record button edges into
// record/play/pause modes, drives the sram address and issues per-frame write/read strobes.
module rec_ctrl #(
   parameter int unsigned ADDR_W = 18
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              play_i,
   input  logic              record_i,
   input  logic              sample_tick_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              write_o,
   output logic              read_o,
   output logic              rec_en_o,
   output logic              play_en_o,
   output logic [ADDR_W:0]   sample_count_o,
   output logic              full_o,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRecord = 2'd1,
      StPlay   = 2'd2,
      StPause  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                play_q, record_q;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                write_q, write_d;
   logic                read_q, read_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                full_q, full_d;

   logic                play_rise, record_rise;
   logic [ADDR_W:0]     ptr_inc;

   assign play_rise   = play_i & ~play_q;
   assign record_rise = record_i & ~record_q;
   // One wider than ptr so the count can reach 2^ADDR_W on a full take.
   assign ptr_inc     = {1'b0, ptr_q} + (ADDR_W+1)'(1);

   // Next-state: button edges first (record over play), then the frame tick.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      write_d = 1'b0;
      read_d  = 1'b0;
      count_d = count_q;
      full_d  = full_q;
      unique case (state_q)
         StIdle: begin
            if (record_rise) begin
               state_d = StRecord;
               ptr_d   = '0;
               count_d = '0;
               full_d  = 1'b0;
            end else if (play_rise && (count_q != '0)) begin
               state_d = StPlay;
               ptr_d   = '0;
            end
         end
         StRecord: begin
            if (record_rise) begin
               state_d = StIdle;
            end else if (!play_rise && sample_tick_i) begin
               write_d = 1'b1;
               addr_d  = ptr_q;
               ptr_d   = ptr_inc[ADDR_W-1:0];
               count_d = ptr_inc;
               if (&ptr_q) begin
                  full_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StPlay: begin
            if (record_rise) begin
               state_d = StIdle;
            end else if (play_rise) begin
               state_d = StPause;
            end else if (sample_tick_i) begin
               read_d = 1'b1;
               addr_d = ptr_q;
               ptr_d  = ptr_inc[ADDR_W-1:0];
               if (ptr_inc == count_q) begin
                  state_d = StIdle;
               end
            end
         end
         StPause: begin
            if (record_rise) begin
               state_d = StIdle;
            end else if (play_rise) begin
               state_d = StPlay;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; button history follows the inputs during reset so a held
   // button does not produce an edge when reset releases.
   always_ff @(posedge clk_i) begin
      play_q   <= play_i;
      record_q <= record_i;
      if (reset_i) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         read_q  <= 1'b0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         read_q  <= read_d;
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   // Outputs decode straight from registers.
   always_comb begin
      addr_o         = addr_q;
      write_o        = write_q;
      read_o         = read_q;
      rec_en_o       = (state_q == StRecord);
      play_en_o      = (state_q == StPlay);
      sample_count_o = count_q;
      full_o         = full_q;
      state_o        = state_q;
   end

endmodule

// File: tb/tb_rec_ctrl.sv
// Self-checking bench for rec_ctrl: directed scenarios plus a randomized run against a
// transaction-level model of the recorder.
module tb_rec_ctrl;
   localparam int unsigned AW = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          play = 1'b0;
   logic          record = 1'b0;
   logic          tick = 1'b0;
   logic [AW-1:0] addr;
   logic          write, read, rec_en, play_en, full;
   logic [AW:0]   count;
   logic [1:0]    state;

   int n_checks = 0;
   int n_pass = 0;

   // Model: mode 0 idle, 1 record, 2 play, 3 pause; take length and play position.
   int   m_mode, m_pos, m_len, m_addr;
   logic m_wr, m_rd, m_full, m_pp, m_pr;

   rec_ctrl #(.ADDR_W(AW)) dut (
      .clk_i(clk), .reset_i(reset), .play_i(play), .record_i(record),
      .sample_tick_i(tick), .addr_o(addr), .write_o(write), .read_o(read),
      .rec_en_o(rec_en), .play_en_o(play_en), .sample_count_o(count),
      .full_o(full), .state_o(state)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic rst, input logic p, input logic r, input logic t);
      logic pr, rr;
      pr = p && !m_pp;
      rr = r && !m_pr;
      m_pp = p;
      m_pr = r;
      m_wr = 1'b0;
      m_rd = 1'b0;
      if (rst) begin
         m_mode = 0; m_pos = 0; m_len = 0; m_addr = 0; m_full = 1'b0;
      end else if (rr) begin
         if (m_mode == 0) begin
            m_mode = 1; m_pos = 0; m_len = 0; m_full = 1'b0;
         end else m_mode = 0;
      end else if (pr) begin
         if (m_mode == 0 && m_len > 0) begin
            m_mode = 2; m_pos = 0;
         end else if (m_mode == 2) m_mode = 3;
         else if (m_mode == 3) m_mode = 2;
      end else if (t) begin
         if (m_mode == 1) begin
            m_wr = 1'b1; m_addr = m_pos; m_pos++; m_len = m_pos;
            if (m_pos == DEPTH) begin
               m_full = 1'b1; m_mode = 0; m_pos = 0;
            end
         end else if (m_mode == 2) begin
            m_rd = 1'b1; m_addr = m_pos; m_pos++;
            if (m_pos == m_len) m_mode = 0;
         end
      end
   endtask

   // Drive one cycle of inputs at the falling edge; outputs are sampled 1ns after the rise.
   task automatic step(input logic rst, input logic p, input logic r, input logic t);
      @(negedge clk);
      reset = rst; play = p; record = r; tick = t;
      model_step(rst, p, r, t);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({state, addr, write, read, rec_en, play_en, count, full} !== '0)
         $display("FAIL reset_outputs got st=%0d a=%0d w=%b r=%b re=%b pe=%b c=%0d f=%b want all 0",
                  state, addr, write, read, rec_en, play_en, count, full);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_record_take;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== 2'd1 || rec_en !== 1'b1) $display("FAIL rec_start got st=%0d re=%b want 1 1", state, rec_en);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         n_checks++;
         if (write !== 1'b1 || addr !== AW'(i))
            $display("FAIL rec_write%0d got w=%b a=%0d want w=1 a=%0d", i, write, addr, i);
         else n_pass++;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (write !== 1'b0) $display("FAIL rec_no_extra_write got %b want 0", write);
      else n_pass++;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (count !== 5'd5 || state !== 2'd0 || full !== 1'b0 || rec_en !== 1'b0)
         $display("FAIL rec_end got c=%0d st=%0d f=%b re=%b want 5 0 0 0", count, state, full, rec_en);
      else n_pass++;
   endtask

   task automatic test_playback;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (state !== 2'd2 || play_en !== 1'b1) $display("FAIL play_start got st=%0d pe=%b want 2 1", state, play_en);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         n_checks++;
         if (i < 5) begin
            if (read !== 1'b1 || addr !== AW'(i))
               $display("FAIL play_read%0d got r=%b a=%0d want r=1 a=%0d", i, read, addr, i);
            else n_pass++;
         end else begin
            if (read !== 1'b0) $display("FAIL play_past_end%0d got r=%b want 0", i, read);
            else n_pass++;
         end
         if (i == 4) begin
            n_checks++;
            if (state !== 2'd0 || play_en !== 1'b0)
               $display("FAIL play_last_idle got st=%0d pe=%b want 0 0", state, play_en);
            else n_pass++;
         end
      end
      n_checks++;
      if (count !== 5'd5) $display("FAIL count_persist got %0d want 5", count);
      else n_pass++;
   endtask

   task automatic test_empty_and_priority;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (state !== 2'd0 || read !== 1'b0 || write !== 1'b0)
         $display("FAIL empty_play got st=%0d r=%b w=%b want 0 0 0", state, read, write);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (state !== 2'd1 || write !== 1'b0)
         $display("FAIL both_rise got st=%0d w=%b want 1 0", state, write);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (state !== 2'd1 || write !== 1'b0)
         $display("FAIL play_in_rec_drops_tick got st=%0d w=%b want 1 0", state, write);
      else n_pass++;
   endtask

   task automatic test_pause;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (state !== 2'd3 || play_en !== 1'b0) $display("FAIL pause_enter got st=%0d pe=%b want 3 0", state, play_en);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         n_checks++;
         if (read !== 1'b0) $display("FAIL pause_tick%0d got r=%b want 0", i, read);
         else n_pass++;
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (read !== 1'b1 || addr !== 4'd2 || state !== 2'd2)
         $display("FAIL pause_resume got r=%b a=%0d st=%0d want 1 2 2", read, addr, state);
      else n_pass++;
   endtask

   task automatic test_full;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         n_checks++;
         if (i < 16) begin
            if (write !== 1'b1 || addr !== AW'(i))
               $display("FAIL full_write%0d got w=%b a=%0d want w=1 a=%0d", i, write, addr, i);
            else n_pass++;
         end else begin
            if (write !== 1'b0) $display("FAIL full_17th got w=%b want 0", write);
            else n_pass++;
         end
         if (i == 15) begin
            n_checks++;
            if (full !== 1'b1 || count !== 5'd16 || state !== 2'd0 || rec_en !== 1'b0)
               $display("FAIL full_flags got f=%b c=%0d st=%0d re=%b want 1 16 0 0", full, count, state, rec_en);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_held;
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== 2'd0) $display("FAIL held_no_edge got st=%0d want 0", state);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (state !== 2'd1) $display("FAIL held_new_press got st=%0d want 1", state);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({state, addr, write, read, rec_en, play_en, count, full} !== '0)
         $display("FAIL mid_rec_reset got st=%0d a=%0d w=%b c=%0d want all 0", state, addr, write, count);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      logic p, r, t, rst;
      int errs;
      p = 1'b0; r = 1'b0;
      errs = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) p = ~p;
         if ($urandom_range(0, 39) == 0) r = ~r;
         t = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 499) == 0);
         step(rst, p, r, t);
         n_checks++;
         if (state !== 2'(m_mode) || addr !== AW'(m_addr) || write !== m_wr || read !== m_rd ||
             rec_en !== (m_mode == 1) || play_en !== (m_mode == 2) ||
             count !== (AW+1)'(m_len) || full !== m_full) begin
            errs++;
            if (errs <= 10)
               $display("FAIL rand_cyc%0d got st=%0d a=%0d w=%b r=%b c=%0d f=%b want %0d %0d %b %b %0d %b",
                        i, state, addr, write, read, count, full,
                        m_mode, m_addr, m_wr, m_rd, m_len, m_full);
         end else n_pass++;
      end
   endtask

   initial begin
      model_step(1'b1, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_record_take();
      test_playback();
      test_empty_and_priority();
      test_pause();
      test_full();
      test_reset_held();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
